f_fetch_stage: RTL and testbench

- Pipeline fetch stage plus F/D pipeline register; it is the producer of Instr_D, PC_D and PC_F for the decode stage.
- Consumes npc and Stall from decode and the hazard unit.
- Talks to a variable-latency instruction memory over a req/ack handshake.
- While the memory is slow it inserts nop bubbles into D and keeps a pending next-PC, so delayed-branch redirects are never lost.

---
 rtl/f_fetch_stage.sv | 134 +++++++++++++
 tb/tb_f_fetch_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : f_fetch_stage                                                 |
// | Brief    : Instruction fetch stage with F/D pipeline register. Talks to  |
// |            a variable-latency instruction memory over req/ack, inserts   |
// |            nop bubbles while the memory is slow and keeps a pending      |
// |            next-PC so delayed-branch redirects survive the wait.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module f_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        Stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic        Valid_D,
  output logic        Fetch_Busy
);

  // IDLE : one-cycle gap after reset, no request
  // WAIT : request outstanding at PC_F, address held until ack
  // HOLD : word returned during a stall, parked in hold_reg
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] nxt_pc;     // fetch target recorded while D held a real instruction
  logic [31:0] hold_reg;   // instruction word captured during a stall
  logic [31:0] instr_src;
  logic [31:0] sel_npc;
  logic        have;       // an instruction word is available this cycle
  logic        capture;    // ack arrives while stalled: park the word
  logic        issue;
  logic        bubble;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, memory handshake and availability decode
  always_comb begin
    state_next = state;
    im_req     = 1'b0;
    have       = 1'b0;
    capture    = 1'b0;
    Fetch_Busy = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        im_req     = 1'b1;
        Fetch_Busy = ~im_ack;
        have       = im_ack;
        capture    = im_ack & Stall;
        // On an unstalled ack the next request simply continues in WAIT
        if (im_ack && Stall) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        have = 1'b1;
        if (!Stall) begin
          state_next = ST_WAIT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign im_addr   = PC_F;
  assign issue     = have & ~Stall;
  assign bubble    = ~have & ~Stall;
  assign instr_src = (state == ST_HOLD) ? hold_reg : im_rdata;
  // A bubble in D carries no decode result, so fall back to the stored target
  assign sel_npc   = Valid_D ? npc : nxt_pc;

  // Fetch PC, F/D register and pending next-PC
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F    <= RESET_PC;
      PC_D    <= RESET_PC;
      Instr_D <= NOP_INSTR;
      Valid_D <= 1'b0;
      nxt_pc  <= RESET_PC + 32'd4;
    end else if (issue) begin
      Instr_D <= instr_src;
      PC_D    <= PC_F;
      Valid_D <= 1'b1;
      PC_F    <= sel_npc;
    end else if (bubble) begin
      Instr_D <= NOP_INSTR;
      PC_D    <= PC_F;
      Valid_D <= 1'b0;
      // The instruction leaving D may be a branch: remember where it goes
      // while the delay-slot fetch at PC_F is still outstanding.
      if (Valid_D) begin
        nxt_pc <= npc;
      end
    end
  end

  // Park a word whose ack lands while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg <= 32'h0000_0000;
    end else if (capture) begin
      hold_reg <= im_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_f_fetch_stage                                              |
// | Brief    : Self-checking bench for f_fetch_stage: memory model with      |
// |            programmable latency, decode stand-in for npc, and an         |
// |            architectural model of the delayed-branch fetch stream.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_f_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        im_req;
  logic        im_ack;
  logic        Valid_D;
  logic        Fetch_Busy;
  logic [31:0] npc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;

  int n_cmp   = 0;
  int n_fail  = 0;
  int br_mode = 0;
  int lat_lo  = 1;
  int lat_hi  = 1;
  int lat     = 1;
  int waited  = 0;

  // Architectural model state
  logic [31:0] m_pc_f;
  logic [31:0] m_pc_d;
  logic [31:0] m_instr;
  logic [31:0] m_last_tgt;
  bit          m_valid;
  bit          m_held;
  bit          m_idle;
  bit          m_last_br;

  always #5 clk = ~clk;

  f_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .Stall      (Stall),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .im_ack     (im_ack),
    .PC_F       (PC_F),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .Valid_D    (Valid_D),
    .Fetch_Busy (Fetch_Busy)
  );

  // Decode stand-in: beq (opcode 4) always taken, everything else falls through
  always_comb begin
    npc = PC_F + 32'd4;
    if (Valid_D && Instr_D[31:26] == 6'h04) begin
      npc = PC_D + 32'd4 + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
    end
  end

  // Program image: mode 1 has one beq at 0x3000, mode 2 a beq at every addr[4:2]==4
  function automatic bit is_br(input logic [31:0] a);
    if (br_mode == 1) return (a == RST_PC);
    if (br_mode == 2) return (a[4:2] == 3'b100);
    return 1'b0;
  endfunction

  function automatic logic [15:0] br_off(input logic [31:0] a);
    if (br_mode == 1) return 16'd15;
    return {{11{a[9]}}, a[9:5]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (is_br(a)) return {6'h04, 10'd0, br_off(a)};
    return {6'h08, a[27:2] ^ 26'h2A5_A5A5};
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] a);
    int o;
    o = int'($signed(br_off(a)));
    return a + 32'(4 + o * 4);
  endfunction

  // One clock: memory responds at negedge, model advances at posedge
  task automatic cycle();
    logic [31:0] nxt;
    @(negedge clk);
    if (im_req === 1'b1) begin
      waited++;
      im_ack = (waited >= lat);
    end else begin
      waited = 0;
      im_ack = 1'b0;
    end
    im_rdata = im_ack ? mem_word(im_addr) : $urandom;
    @(posedge clk);
    if (reset) begin
      m_pc_f    = RST_PC;
      m_pc_d    = RST_PC;
      m_instr   = 32'h0;
      m_valid   = 1'b0;
      m_held    = 1'b0;
      m_idle    = 1'b1;
      m_last_br = 1'b0;
    end else begin
      m_idle = 1'b0;
      if (Stall) begin
        if (im_ack) m_held = 1'b1;
      end else if (im_ack || m_held) begin
        nxt        = m_last_br ? m_last_tgt : m_pc_f + 32'd4;
        m_instr    = mem_word(m_pc_f);
        m_pc_d     = m_pc_f;
        m_valid    = 1'b1;
        m_last_br  = is_br(m_pc_f);
        m_last_tgt = br_target(m_pc_f);
        m_pc_f     = nxt;
        m_held     = 1'b0;
      end else begin
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_pc_d  = m_pc_f;
      end
    end
    if (reset || im_ack) begin
      waited = 0;
      lat    = $urandom_range(lat_hi, lat_lo);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Stall = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    br_mode = 0; lat_lo = 1; lat_hi = 1; lat = 1;
    do_reset();
    n_cmp++; if (PC_F !== RST_PC) begin n_fail++; $display("FAIL reset_pc_f: got %h expected %h", PC_F, RST_PC); end
    n_cmp++; if (PC_D !== RST_PC) begin n_fail++; $display("FAIL reset_pc_d: got %h expected %h", PC_D, RST_PC); end
    n_cmp++; if (Instr_D !== 32'h0) begin n_fail++; $display("FAIL reset_instr_d: got %h expected 0", Instr_D); end
    n_cmp++; if (Valid_D !== 1'b0) begin n_fail++; $display("FAIL reset_valid_d: got %b expected 0", Valid_D); end
    n_cmp++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL reset_im_req: got %b expected 0", im_req); end
    n_cmp++; if (Fetch_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Fetch_Busy); end
    cycle();
    n_cmp++; if (im_req !== 1'b1 || im_addr !== RST_PC) begin
      n_fail++; $display("FAIL first_request: got req=%b addr=%h expected req=1 addr=%h", im_req, im_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    int k;
    logic [31:0] a;
    br_mode = 0; lat_lo = 1; lat_hi = 1; lat = 1;
    do_reset();
    k = 0;
    while (Valid_D !== 1'b1 && k < 10) begin cycle(); k++; end
    n_cmp++; if (k != 2) begin n_fail++; $display("FAIL zw_first_issue_latency: got %0d cycles expected 2", k); end
    for (int i = 0; i < 6; i++) begin
      a = RST_PC + 32'(4 * i);
      n_cmp++; if (Instr_D !== mem_word(a)) begin n_fail++; $display("FAIL zw_instr[%0d]: got %h expected %h", i, Instr_D, mem_word(a)); end
      n_cmp++; if (PC_D !== a || Valid_D !== 1'b1) begin n_fail++; $display("FAIL zw_pc_d[%0d]: got %h/%b expected %h/1", i, PC_D, Valid_D, a); end
      n_cmp++; if (PC_F !== a + 32'd4) begin n_fail++; $display("FAIL zw_pc_f[%0d]: got %h expected %h", i, PC_F, a + 32'd4); end
      cycle();
    end
  endtask

  task automatic test_latency();
    int bubbles;
    int issues;
    bit prev_req;
    logic [31:0] prev_addr;
    logic [31:0] prev_pc_f;
    br_mode = 0; lat_lo = 3; lat_hi = 3; lat = 3;
    do_reset();
    bubbles = 0; issues = 0; prev_req = 1'b0; prev_addr = 32'h0; prev_pc_f = PC_F;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (Valid_D === 1'b1) begin
        n_cmp++; if (PC_D !== RST_PC + 32'(4 * issues) || Instr_D !== mem_word(RST_PC + 32'(4 * issues))) begin
          n_fail++; $display("FAIL lat_issue[%0d]: got pc=%h instr=%h expected pc=%h", issues, PC_D, Instr_D, RST_PC + 32'(4 * issues));
        end
        if (issues > 0) begin
          n_cmp++; if (bubbles != 2) begin n_fail++; $display("FAIL lat_bubbles[%0d]: got %0d expected 2", issues, bubbles); end
        end
        issues++;
        bubbles = 0;
      end else begin
        bubbles++;
        n_cmp++; if (Instr_D !== 32'h0 || PC_F !== prev_pc_f) begin
          n_fail++; $display("FAIL lat_bubble_hold: got instr=%h pc_f=%h expected 0/%h", Instr_D, PC_F, prev_pc_f);
        end
        if (prev_req && im_req === 1'b1) begin
          n_cmp++; if (im_addr !== prev_addr) begin n_fail++; $display("FAIL lat_addr_stable: got %h expected %h", im_addr, prev_addr); end
        end
      end
      prev_req = (im_req === 1'b1); prev_addr = im_addr; prev_pc_f = PC_F;
    end
    n_cmp++; if (issues < 10) begin n_fail++; $display("FAIL lat_throughput: got %0d issues expected >=10", issues); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_iss [4];
    logic [31:0] exp_req [3];
    logic [31:0] got_iss [$];
    logic [31:0] got_req [$];
    int c;
    exp_iss = '{32'h3000, 32'h3004, 32'h3040, 32'h3044};
    exp_req = '{32'h3000, 32'h3004, 32'h3040};
    br_mode = 1; lat_lo = 2; lat_hi = 2; lat = 2;
    do_reset();
    c = 0;
    while (got_iss.size() < 4 && c < 60) begin
      cycle();
      c++;
      if (im_req === 1'b1 && (got_req.size() == 0 || got_req[$] !== im_addr)) got_req.push_back(im_addr);
      if (Valid_D === 1'b1) got_iss.push_back(PC_D);
    end
    n_cmp++; if (got_iss.size() < 4 || got_req.size() < 3) begin
      n_fail++; $display("FAIL br_timeout: got %0d issues %0d requests expected 4/3", got_iss.size(), got_req.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (got_iss[i] !== exp_iss[i]) begin n_fail++; $display("FAIL br_issue[%0d]: got %h expected %h", i, got_iss[i], exp_iss[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (got_req[i] !== exp_req[i]) begin n_fail++; $display("FAIL br_request[%0d]: got %h expected %h", i, got_req[i], exp_req[i]); end
      end
    end
  endtask

  task automatic test_stall_hold();
    int k;
    br_mode = 0; lat_lo = 1; lat_hi = 1; lat = 1;
    do_reset();
    k = 0;
    while (!(im_req === 1'b1 && im_addr === 32'h3008 && PC_D === 32'h3004) && k < 20) begin cycle(); k++; end
    n_cmp++; if (k >= 20) begin n_fail++; $display("FAIL stall_setup_timeout: got addr=%h expected 00003008", im_addr); end
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (im_req !== 1'b0 || Fetch_Busy !== 1'b0) begin
        n_fail++; $display("FAIL stall_no_request[%0d]: got req=%b busy=%b expected 0/0", i, im_req, Fetch_Busy);
      end
      n_cmp++; if (PC_D !== 32'h3004 || Valid_D !== 1'b1 || PC_F !== 32'h3008) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got pc_d=%h v=%b pc_f=%h expected 3004/1/3008", i, PC_D, Valid_D, PC_F);
      end
    end
    Stall = 1'b0;
    cycle();
    n_cmp++; if (Instr_D !== mem_word(32'h3008) || PC_D !== 32'h3008 || PC_F !== 32'h300C || Valid_D !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got instr=%h pc_d=%h pc_f=%h v=%b expected %h/3008/300c/1", Instr_D, PC_D, PC_F, Valid_D, mem_word(32'h3008));
    end
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h300C) begin
      n_fail++; $display("FAIL stall_next_request: got req=%b addr=%h expected 1/300c", im_req, im_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    int k;
    br_mode = 0; lat_lo = 3; lat_hi = 3; lat = 3;
    do_reset();
    k = 0;
    while (!(Valid_D === 1'b1 && PC_D === 32'h3004) && k < 40) begin cycle(); k++; end
    n_cmp++; if (k >= 40) begin n_fail++; $display("FAIL rw_setup_timeout: got pc_d=%h expected 00003004", PC_D); end
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++; if (PC_F !== RST_PC || PC_D !== RST_PC || Instr_D !== 32'h0 || Valid_D !== 1'b0 || im_req !== 1'b0) begin
      n_fail++; $display("FAIL rw_reset_state: got pc_f=%h pc_d=%h instr=%h v=%b req=%b expected %h/%h/0/0/0", PC_F, PC_D, Instr_D, Valid_D, im_req, RST_PC, RST_PC);
    end
    cycle();
    n_cmp++; if (im_req !== 1'b1 || im_addr !== RST_PC) begin
      n_fail++; $display("FAIL rw_next_request: got req=%b addr=%h expected 1/%h", im_req, im_addr, RST_PC);
    end
    k = 0;
    while (Valid_D !== 1'b1 && k < 10) begin cycle(); k++; end
    n_cmp++; if (PC_D !== RST_PC || Instr_D !== mem_word(RST_PC) || Valid_D !== 1'b1) begin
      n_fail++; $display("FAIL rw_first_issue: got pc_d=%h instr=%h v=%b expected %h/%h/1", PC_D, Instr_D, Valid_D, RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_random();
    bit exp_req;
    br_mode = 2; lat_lo = 1; lat_hi = 4; lat = 1;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      Stall = ($urandom_range(3, 0) == 0);
      reset = ($urandom_range(199, 0) == 0);
      cycle();
      exp_req = !m_idle && !m_held;
      n_cmp++; if (PC_F !== m_pc_f) begin n_fail++; $display("FAIL rnd_pc_f @%0d: got %h expected %h", c, PC_F, m_pc_f); end
      n_cmp++; if (PC_D !== m_pc_d) begin n_fail++; $display("FAIL rnd_pc_d @%0d: got %h expected %h", c, PC_D, m_pc_d); end
      n_cmp++; if (Instr_D !== m_instr) begin n_fail++; $display("FAIL rnd_instr_d @%0d: got %h expected %h", c, Instr_D, m_instr); end
      n_cmp++; if (Valid_D !== m_valid) begin n_fail++; $display("FAIL rnd_valid_d @%0d: got %b expected %b", c, Valid_D, m_valid); end
      n_cmp++; if (im_req !== exp_req) begin n_fail++; $display("FAIL rnd_im_req @%0d: got %b expected %b", c, im_req, exp_req); end
      n_cmp++; if (im_addr !== m_pc_f) begin n_fail++; $display("FAIL rnd_im_addr @%0d: got %h expected %h", c, im_addr, m_pc_f); end
      n_cmp++; if (Fetch_Busy !== (exp_req && !im_ack)) begin
        n_fail++; $display("FAIL rnd_busy @%0d: got %b expected %b", c, Fetch_Busy, exp_req && !im_ack);
      end
    end
    reset = 1'b0;
    Stall = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    Stall    = 1'b0;
    im_ack   = 1'b0;
    im_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_branch();
    test_stall_hold();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
